mux_sel_sequencer: RTL and testbench

Sequential controller that drives the select side of the six-source priority select mux (A[5:0] selected by C[4:0] plus the late control bit) and reads its single-bit Z output. On a start request it walks the enabled source indices in ascending order, drives the priority-correct control word for each, waits a programmable settle time, and captures Z. The result is a packed 6-bit snapshot of the requested sources, with a done pulse. It is the initiator/reader end of the mux's select interface.

---
 rtl/mux_sel_pkg.sv | 49 ++++
 rtl/mux_sel_enc.sv | 30 +++
 rtl/mux_sel_sequencer.sv | 138 +++++++++++++
 tb/tb_mux_sel_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
`default_nettype none
//==============================================================================
// Package : mux_sel_pkg
// Shared widths, select-word type, canonical encodings and FSM states.
// Rev     : 1.0
//==============================================================================
package mux_sel_pkg;

    localparam int NUM_SRC = 6;
    localparam int IDX_W   = 3;
    localparam int C_W     = 5;

    typedef struct packed {
        logic           ctrl_late;
        logic [C_W-1:0] c;
    } sel_word_t;

    localparam sel_word_t c_sel_idx0      = '{ctrl_late: 1'b0, c: 5'b00001};
    localparam sel_word_t c_sel_idx1      = '{ctrl_late: 1'b0, c: 5'b00000};
    localparam sel_word_t c_sel_idx2      = '{ctrl_late: 1'b0, c: 5'b00110};
    localparam sel_word_t c_sel_idx3      = '{ctrl_late: 1'b0, c: 5'b01010};
    localparam sel_word_t c_sel_idx4      = '{ctrl_late: 1'b0, c: 5'b00010};
    localparam sel_word_t c_sel_idx4_late = '{ctrl_late: 1'b1, c: 5'b01010};
    localparam sel_word_t c_sel_idx5      = '{ctrl_late: 1'b0, c: 5'b10010};
    localparam sel_word_t c_sel_idle      = c_sel_idx0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index of the lowest set bit; 0 for an empty mask.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_SRC-1:0] m);
        lowest_set = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    function automatic logic [NUM_SRC-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (IDX_W'(i) == idx) idx_onehot[i] = 1'b1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_sel_enc.sv
`default_nettype none
//==============================================================================
// Module : mux_sel_enc
// Source index to priority-correct {ctrl_late, C} select word.
// Rev    : 1.0
//==============================================================================
module mux_sel_enc
    import mux_sel_pkg::*;
#(
    parameter int USE_LATE = 0
) (
    input  logic [IDX_W-1:0] idx,
    output sel_word_t        word
);

    always_comb begin
        word = c_sel_idle;
        case (idx)
            3'd0:    word = c_sel_idx0;
            3'd1:    word = c_sel_idx1;
            3'd2:    word = c_sel_idx2;
            3'd3:    word = c_sel_idx3;
            3'd4:    word = (USE_LATE != 0) ? c_sel_idx4_late : c_sel_idx4;
            3'd5:    word = c_sel_idx5;
            default: word = c_sel_idle;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mux_sel_sequencer.sv
`default_nettype none
//==============================================================================
// Module : mux_sel_sequencer
// Walks enabled mux sources in ascending order, settles, samples Z into result.
// Rev    : 1.0
//==============================================================================
module mux_sel_sequencer
    import mux_sel_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int USE_LATE      = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NUM_SRC-1:0] src_mask,
    input  logic               z_in,
    output logic [C_W-1:0]     c_out,
    output logic               ctrl_late,
    output logic               busy,
    output logic               done,
    output logic [NUM_SRC-1:0] result
);

    localparam logic [3:0] c_cnt_reload = 4'(SETTLE_CYCLES - 1);

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_cnt, w_cnt_nxt;
    logic [NUM_SRC-1:0] r_mask, w_mask_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    sel_word_t          r_sel, w_sel_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [NUM_SRC-1:0] r_result, w_result_nxt;

    logic [NUM_SRC-1:0] w_mask_cleared;
    logic [NUM_SRC-1:0] w_scan_mask;
    logic [IDX_W-1:0]   w_enc_idx;
    sel_word_t          w_enc_word;

    // One encoder serves both the first index (from src_mask) and every later one.
    assign w_mask_cleared = r_mask & ~idx_onehot(r_idx);
    assign w_scan_mask    = (r_state == ST_IDLE) ? src_mask : w_mask_cleared;
    assign w_enc_idx      = lowest_set(w_scan_mask);

    mux_sel_enc #(
        .USE_LATE (USE_LATE)
    ) u_enc (
        .idx  (w_enc_idx),
        .word (w_enc_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_mask   <= '0;
            r_idx    <= '0;
            r_sel    <= c_sel_idle;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mask   <= w_mask_nxt;
            r_idx    <= w_idx_nxt;
            r_sel    <= w_sel_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_mask_nxt   = r_mask;
        w_idx_nxt    = r_idx;
        w_sel_nxt    = r_sel;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;

        case (r_state)
            ST_IDLE: begin
                // r_done blocks a start that lands in the done cycle.
                if (start && !r_done) begin
                    w_result_nxt = '0;
                    if (src_mask != '0) begin
                        w_mask_nxt  = src_mask;
                        w_idx_nxt   = w_enc_idx;
                        w_sel_nxt   = w_enc_word;
                        w_cnt_nxt   = c_cnt_reload;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_result_nxt = r_result | ({NUM_SRC{z_in}} & idx_onehot(r_idx));
                    w_mask_nxt   = w_mask_cleared;
                    if (w_mask_cleared != '0) begin
                        w_idx_nxt = w_enc_idx;
                        w_sel_nxt = w_enc_word;
                        w_cnt_nxt = c_cnt_reload;
                    end else begin
                        w_sel_nxt   = c_sel_idle;
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = c_sel_idle;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign c_out     = r_sel.c;
    assign ctrl_late = r_sel.ctrl_late;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
`default_nettype none
//==============================================================================
// Module : tb_mux_sel_sequencer
// Randomized self-checking bench with a behavioural mux and sequencing model.
// Rev    : 1.0
//==============================================================================
module tb_mux_sel_sequencer;

    logic       clk;
    logic [1:0] rst_n;
    logic [1:0] start;
    logic [5:0] src_mask [2];
    logic [4:0] c_out    [2];
    logic [1:0] ctrl_late;
    logic [1:0] busy;
    logic [1:0] done;
    logic [5:0] result   [2];
    logic [7:0] a_val    [2];
    logic       z0, z1;

    int n_checks = 0;
    int n_fails  = 0;

    // Instance 0: SETTLE_CYCLES=1, USE_LATE=0.  Instance 1: SETTLE_CYCLES=3, USE_LATE=1.
    function automatic int settle_of(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    // Canonical {ctrl_late, C} word for source idx on instance d.
    function automatic logic [5:0] exp_word(input int d, input int idx);
        case (idx)
            0:       return 6'b0_00001;
            1:       return 6'b0_00000;
            2:       return 6'b0_00110;
            3:       return 6'b0_01010;
            4:       return (d == 1) ? 6'b1_01010 : 6'b0_00010;
            5:       return 6'b0_10010;
            default: return 6'b0_00001;
        endcase
    endfunction

    // Behavioural mux: whichever source the select word addresses drives Z.
    function automatic logic mux_model(input int d, input logic [5:0] word, input logic [7:0] a);
        for (int i = 0; i < 6; i++) begin
            if (word == exp_word(d, i)) return a[i];
        end
        return 1'b0;
    endfunction

    assign z0 = mux_model(0, {ctrl_late[0], c_out[0]}, a_val[0]);
    assign z1 = mux_model(1, {ctrl_late[1], c_out[1]}, a_val[1]);

    mux_sel_sequencer #(.SETTLE_CYCLES(1), .USE_LATE(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n[0]),
        .start     (start[0]),
        .src_mask  (src_mask[0]),
        .z_in      (z0),
        .c_out     (c_out[0]),
        .ctrl_late (ctrl_late[0]),
        .busy      (busy[0]),
        .done      (done[0]),
        .result    (result[0])
    );

    mux_sel_sequencer #(.SETTLE_CYCLES(3), .USE_LATE(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n[1]),
        .start     (start[1]),
        .src_mask  (src_mask[1]),
        .z_in      (z1),
        .c_out     (c_out[1]),
        .ctrl_late (ctrl_late[1]),
        .busy      (busy[1]),
        .done      (done[1]),
        .result    (result[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input int d, input string tag);
        check({tag, "_word"},   32'({ctrl_late[d], c_out[d]}), 32'(6'b0_00001));
        check({tag, "_busy"},   32'(busy[d]),   32'd0);
        check({tag, "_done"},   32'(done[d]),   32'd0);
        check({tag, "_result"}, 32'(result[d]), 32'd0);
    endtask

    // One request on instance d; every cycle is checked against the expected timeline.
    task automatic run(input int d, input logic [5:0] mask, input logic [7:0] a, input bit repulse);
        int idxs[$];
        int s     = settle_of(d);
        int n;
        int tdone;
        for (int i = 0; i < 6; i++) if (mask[i]) idxs.push_back(i);
        n     = idxs.size();
        tdone = (n == 0) ? 0 : n * s + 1;
        a_val[d] = a;
        @(negedge clk);
        src_mask[d] = mask;
        start[d]    = 1'b1;
        @(posedge clk);
        #1;
        start[d]    = 1'b0;
        src_mask[d] = 6'($urandom);
        for (int t = 0; t <= tdone + 1; t++) begin
            @(negedge clk);
            if (t < n * s) begin
                check("seq_word", 32'({ctrl_late[d], c_out[d]}), 32'(exp_word(d, idxs[t / s])));
                check("seq_busy", 32'(busy[d]), 32'd1);
            end else if (t < tdone) begin
                check("done_state_idle_word", 32'({ctrl_late[d], c_out[d]}), 32'(6'b0_00001));
            end
            check("done_timing", 32'(done[d]), 32'(t == tdone));
            if (repulse && n * s >= 3 && t == 1) begin
                start[d]    = 1'b1;
                src_mask[d] = ~mask;
            end
            if (repulse && n * s >= 3 && t == 2) start[d] = 1'b0;
            if (t == tdone) begin
                check("done_busy", 32'(busy[d]), 32'd0);
                check("result", 32'(result[d]), 32'(a[5:0] & mask));
                start[d]    = 1'b1;
                src_mask[d] = 6'h3f;
            end
            if (t == tdone + 1) begin
                check("start_in_done_ignored", 32'(busy[d]), 32'd0);
                check("result_hold", 32'(result[d]), 32'(a[5:0] & mask));
                start[d] = 1'b0;
            end
        end
    endtask

    task automatic reset_mid_run(input int d);
        a_val[d] = 8'hff;
        @(negedge clk);
        src_mask[d] = 6'h3f;
        start[d]    = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[d] = 1'b0;
        #1;
        check_reset_vals(d, "async_rst");
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", 32'(done[d]), 32'd0);
        end
        rst_n[d] = 1'b1;
        @(negedge clk);
        check_reset_vals(d, "post_rst");
    endtask

    initial begin
        rst_n       = 2'b00;
        start       = 2'b00;
        src_mask[0] = '0;
        src_mask[1] = '0;
        a_val[0]    = '0;
        a_val[1]    = '0;
        repeat (3) @(negedge clk);
        check_reset_vals(0, "reset0");
        check_reset_vals(1, "reset1");
        rst_n = 2'b11;

        run(0, 6'b111111, 8'hA5, 1'b0);
        run(1, 6'b010000, 8'h10, 1'b0);
        run(1, 6'b100001, 8'h21, 1'b0);
        run(0, 6'b010000, 8'hff, 1'b0);
        run(0, 6'b000000, 8'hff, 1'b0);
        run(1, 6'b000000, 8'hff, 1'b0);
        run(0, 6'b101010, 8'h3f, 1'b1);
        run(1, 6'b000110, 8'h04, 1'b1);
        reset_mid_run(0);
        run(0, 6'b110011, 8'h5a, 1'b0);
        reset_mid_run(1);
        run(1, 6'b011101, 8'h3c, 1'b0);

        for (int k = 0; k < 40; k++) begin
            run(k % 2, 6'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
